// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, borrow out of this bit position.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ bin;
  assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per cycle through a single full_subtractor.
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fs_diff, fs_borrow;

  assign last = (cnt == LAST);

  // borrow doubles as the running borrow flop; it ends holding the MSB borrow-out
  full_subtractor u_fs (
    .a      (sh_a[0]),
    .b      (sh_b[0]),
    .bin    (borrow),
    .diff   (fs_diff),
    .borrow (fs_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // diff is the result shift register: after WIDTH shifts it holds the full difference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a   <= a;
            sh_b   <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          diff   <= {fs_diff, diff[WIDTH-1:1]};
          borrow <= fs_borrow;
          cnt    <= cnt + 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          // overflow when borrow into the sign bit differs from borrow out of it
          if (last) ovf <= borrow ^ fs_borrow;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
